// File: rtl/detection_event_logger.sv
// detection_event_logger: counts A/B detections and queues timestamped records in a show-ahead FIFO
module detection_event_logger #(
  parameter int CNT_W = 8,
  parameter int TS_W = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [1:0]               z,
  input  logic                     clear,
  output logic [CNT_W-1:0]         count_a,
  output logic [CNT_W-1:0]         count_b,
  output logic                     evt_valid,
  input  logic                     evt_ready,
  output logic                     evt_type,
  output logic [TS_W-1:0]          evt_time,
  output logic [$clog2(DEPTH):0]   fill,
  output logic                     overflow,
  output logic                     illegal
);
  localparam int AW = $clog2(DEPTH);
  localparam int FW = AW + 1;
  localparam logic EMPTY = 1'b0;
  localparam logic NONEMPTY = 1'b1;
  logic [TS_W:0] mem [DEPTH];
  logic [TS_W:0] head;
  logic [TS_W-1:0] ts;
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic state, state_next;
  logic evt, pop, full, push;
  always_comb begin
    evt = z[1];
    pop = (state == NONEMPTY) && evt_ready;
    full = fill == FW'(DEPTH);
    push = evt && (!full || pop);
    head = mem[rd_ptr];
    evt_valid = state == NONEMPTY;
    evt_type = evt_valid ? head[TS_W] : 1'b0;
    evt_time = evt_valid ? head[TS_W-1:0] : '0;
    state_next = (push && !pop) ? NONEMPTY :
                 (pop && !push && fill == FW'(1)) ? EMPTY : state;
  end
  // Slots are written without reset; the head is masked while empty.
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= {z[0], ts};
  always_ff @(posedge clk) begin
    if (rst) begin
      ts <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      fill <= '0;
      state <= EMPTY;
      count_a <= '0;
      count_b <= '0;
      overflow <= 1'b0;
      illegal <= 1'b0;
    end else begin
      ts <= ts + TS_W'(1);
      state <= state_next;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      if (push != pop) fill <= push ? fill + FW'(1) : fill - FW'(1);
      if (clear) begin
        count_a <= '0;
        count_b <= '0;
        overflow <= 1'b0;
        illegal <= 1'b0;
      end else begin
        if (evt && !z[0] && !(&count_a)) count_a <= count_a + CNT_W'(1);
        if (evt && z[0] && !(&count_b)) count_b <= count_b + CNT_W'(1);
        if (evt && !push) overflow <= 1'b1;
        if (z == 2'b01) illegal <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_detection_event_logger.sv
// tb_detection_event_logger: directed plus random stimulus against a queue-based reference model
module tb_detection_event_logger;
  localparam int CNT_W = 2;
  localparam int TS_W = 4;
  localparam int DEPTH = 4;
  logic clk = 0;
  logic rst, clear, evt_ready;
  logic [1:0] z;
  logic [CNT_W-1:0] count_a, count_b;
  logic evt_valid, evt_type, overflow, illegal;
  logic [TS_W-1:0] evt_time;
  logic [2:0] fill;
  int checks = 0;
  int errors = 0;
  int m_ca, m_cb, m_ts;
  logic m_ov, m_il;
  logic [TS_W:0] q[$];

  detection_event_logger #(.CNT_W(CNT_W), .TS_W(TS_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .z(z), .clear(clear), .count_a(count_a), .count_b(count_b),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_type(evt_type), .evt_time(evt_time),
    .fill(fill), .overflow(overflow), .illegal(illegal));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    assert (act === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic model(input logic r, input logic [1:0] zz, input logic c, input logic rd);
    int sat;
    logic pop, acc;
    sat = (1 << CNT_W) - 1;
    if (r) begin
      q.delete();
      m_ts = 0; m_ca = 0; m_cb = 0; m_ov = 0; m_il = 0;
    end else begin
      pop = q.size() > 0 && rd;
      acc = zz[1] && (q.size() < DEPTH || pop);
      if (pop) void'(q.pop_front());
      if (acc) q.push_back({zz[0], m_ts[TS_W-1:0]});
      if (c) begin
        m_ca = 0; m_cb = 0; m_ov = 0; m_il = 0;
      end else begin
        if (zz == 2'b10 && m_ca < sat) m_ca++;
        if (zz == 2'b11 && m_cb < sat) m_cb++;
        if (zz[1] && !acc) m_ov = 1;
        if (zz == 2'b01) m_il = 1;
      end
      m_ts = (m_ts + 1) % (1 << TS_W);
    end
  endtask

  task automatic step(input logic r, input logic [1:0] zz, input logic c, input logic rd);
    rst = r; z = zz; clear = c; evt_ready = rd;
    @(posedge clk);
    model(r, zz, c, rd);
    #1;
    check("count_a", count_a, m_ca);
    check("count_b", count_b, m_cb);
    check("fill", fill, q.size());
    check("evt_valid", evt_valid, q.size() > 0);
    check("evt_type", evt_type, q.size() > 0 ? q[0][TS_W] : 1'b0);
    check("evt_time", evt_time, q.size() > 0 ? q[0][TS_W-1:0] : '0);
    check("overflow", overflow, m_ov);
    check("illegal", illegal, m_il);
  endtask

  initial begin
    logic [1:0] rz;
    step(1, 2'b10, 0, 1);
    step(1, 2'b11, 1, 1);
    check("reset_fill", fill, 0);
    check("reset_valid", evt_valid, 0);
    // A at ts0, B at ts2
    step(0, 2'b10, 0, 0);
    step(0, 2'b00, 0, 0);
    step(0, 2'b11, 0, 0);
    step(0, 2'b00, 0, 0);
    check("ab_fill", fill, 2);
    check("ab_head_type", evt_type, 0);
    check("ab_head_time", evt_time, 0);
    step(0, 2'b00, 0, 1);
    check("ab_second_type", evt_type, 1);
    check("ab_second_time", evt_time, 2);
    step(0, 2'b00, 0, 1);
    // overflow with five A events
    step(1, 2'b00, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 2'b10, 0, 0);
    check("ovf_fill", fill, 4);
    check("ovf_count_a", count_a, 3);
    check("ovf_flag", overflow, 1);
    for (int i = 0; i < 4; i++) begin
      check("ovf_drain_time", evt_time, i);
      step(0, 2'b00, 0, 1);
    end
    // full FIFO with simultaneous push and pop
    step(1, 2'b00, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 2'b10, 0, 0);
    step(0, 2'b11, 0, 1);
    check("fullpp_fill", fill, 4);
    check("fullpp_ovf", overflow, 0);
    for (int i = 0; i < 3; i++) step(0, 2'b00, 0, 1);
    check("fullpp_last_type", evt_type, 1);
    check("fullpp_last_time", evt_time, 4);
    step(0, 2'b00, 0, 1);
    // saturation then clear with an A event
    step(1, 2'b00, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 2'b11, 0, 1);
    check("sat_count_b", count_b, 3);
    check("sat_fill_before", fill, 1);
    step(0, 2'b10, 1, 0);
    check("clr_count_a", count_a, 0);
    check("clr_count_b", count_b, 0);
    check("clr_fill", fill, 2);
    // illegal code
    step(0, 2'b01, 0, 0);
    check("ill_flag", illegal, 1);
    check("ill_fill", fill, 2);
    // timestamp wrap: event at post-reset edge 17
    step(1, 2'b00, 0, 0);
    for (int i = 0; i < 16; i++) step(0, 2'b00, 0, 0);
    step(0, 2'b10, 0, 0);
    check("wrap_time", evt_time, 0);
    check("wrap_valid", evt_valid, 1);
    // reset mid-drain
    for (int i = 0; i < 2; i++) step(0, 2'b10, 0, 0);
    step(1, 2'b10, 0, 1);
    check("rstmid_valid", evt_valid, 0);
    check("rstmid_fill", fill, 0);
    check("rstmid_count_a", count_a, 0);
    // random traffic
    for (int i = 0; i < 400; i++) begin
      rz = 2'($urandom_range(0, 3));
      if (rz == 2'b01 && $urandom_range(0, 3) != 0) rz = 2'b00;
      step($urandom_range(0, 99) == 0, rz, $urandom_range(0, 29) == 0, 1'($urandom_range(0, 1)));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
